// File: rtl/des_pkg.sv
// ---------------------------------------------------------------------------
// des_pkg : shared widths, default timeout and FSM encoding for the DES arbiter
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package des_pkg;
  localparam int MSG_W           = 64;
  localparam int KEYS_W          = 768;
  localparam int CNT_W           = 16;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;
endpackage

`default_nettype wire

// File: rtl/des_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// des_rr_arbiter2 : two-way round-robin select with a most-recent-grant pointer
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module des_rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic update,
  input  logic update_idx,
  output logic grant_idx
);

  logic last_q;
  logic last_d;

  // On a tie the requester that was not granted last wins; otherwise the
  // single active requester (or 0 when idle, which the caller ignores).
  always_comb begin
    if (req0 && req1) grant_idx = ~last_q;
    else              grant_idx = req1;
  end

  always_comb begin
    last_d = last_q;
    if (update) last_d = update_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

`default_nettype wire

// File: rtl/des_core_arbiter.sv
// ---------------------------------------------------------------------------
// des_core_arbiter : shares one DES encryption core between two requesters
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module des_core_arbiter
  import des_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [MSG_W-1:0]  msg0,
  input  logic [MSG_W-1:0]  msg1,
  input  logic [KEYS_W-1:0] keys0,
  input  logic [KEYS_W-1:0] keys1,
  output logic              ack0,
  output logic              ack1,
  output logic              valid0,
  output logic              valid1,
  output logic [MSG_W-1:0]  result,
  output logic              err,
  output logic              busy,
  output logic              core_start,
  output logic [MSG_W-1:0]  core_message,
  output logic [KEYS_W-1:0] core_round_keys,
  input  logic              core_done,
  input  logic [MSG_W-1:0]  core_result
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MSG_W-1:0]  result_q, result_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              valid0_q, valid0_d, valid1_q, valid1_d;
  logic [MSG_W-1:0]  msg_q, msg_d;
  logic [KEYS_W-1:0] keys_q, keys_d;
  logic              arb_idx;
  logic              arb_update;

  des_rr_arbiter2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req0),
    .req1       (req1),
    .update     (arb_update),
    .update_idx (gnt_q),
    .grant_idx  (arb_idx)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    err_d      = err_q;
    msg_d      = msg_q;
    keys_d     = keys_q;
    start_d    = 1'b0;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    valid0_d   = 1'b0;
    valid1_d   = 1'b0;
    arb_update = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_d = ST_ISSUE;
          gnt_d   = arb_idx;
          msg_d   = arb_idx ? msg1  : msg0;
          keys_d  = arb_idx ? keys1 : keys0;
          start_d = 1'b1;
          ack0_d  = ~arb_idx;
          ack1_d  = arb_idx;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        // A completion in the final timeout cycle still counts as success.
        if (core_done) begin
          state_d  = ST_RESP;
          result_d = core_result;
          err_d    = 1'b0;
          valid0_d = ~gnt_q;
          valid1_d = gnt_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_RESP;
          result_d = '0;
          err_d    = 1'b1;
          valid0_d = ~gnt_q;
          valid1_d = gnt_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d    = ST_IDLE;
        arb_update = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
    end
  end

  // Core operands are only meaningful after a grant, so they carry no reset.
  always_ff @(posedge clk) begin
    msg_q  <= msg_d;
    keys_q <= keys_d;
  end

  assign ack0            = ack0_q;
  assign ack1            = ack1_q;
  assign valid0          = valid0_q;
  assign valid1          = valid1_q;
  assign result          = result_q;
  assign err             = err_q;
  assign busy            = busy_q;
  assign core_start      = start_q;
  assign core_message    = msg_q;
  assign core_round_keys = keys_q;

endmodule

`default_nettype wire

// File: tb/tb_des_core_arbiter.sv
// ---------------------------------------------------------------------------
// tb_des_core_arbiter : scoreboard bench for des_core_arbiter with a DES core stub
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_des_core_arbiter;

  localparam int TO = 16;
  localparam logic [63:0] PT = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT = 64'h85E813540F0AB405;
  localparam logic [767:0] KS = {
    48'b000110_110000_001011_101111_111111_000111_000001_110010,
    48'b011110_011010_111011_011001_110110_111100_100111_100101,
    48'b010101_011111_110010_001010_010000_101100_111110_011001,
    48'b011100_101010_110111_010110_110110_110011_010100_011101,
    48'b011111_001110_110000_000111_111010_110101_001110_101000,
    48'b011000_111010_010100_111110_010100_000111_101100_101111,
    48'b111011_001000_010010_110111_111101_100001_100010_111100,
    48'b111101_111000_101000_111010_110000_010011_101111_111011,
    48'b111000_001101_101111_101011_111011_011110_011110_000001,
    48'b101100_011111_001101_000111_101110_100100_011001_001111,
    48'b001000_010101_111111_010011_110111_101101_001110_000110,
    48'b011101_010111_000111_110101_100101_000110_011111_101001,
    48'b100101_111100_010111_010001_111110_101011_101001_000001,
    48'b010111_110100_001110_110111_111100_101110_011100_111010,
    48'b101111_111001_000110_001101_001111_010011_111100_001010,
    48'b110010_110011_110110_001011_000011_100001_011111_110101
  };

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [63:0]  msg0 = '0, msg1 = '0;
  logic [767:0] keys0 = '0, keys1 = '0;
  logic         ack0, ack1, valid0, valid1, err, busy, core_start, core_done;
  logic [63:0]  result, core_message, core_result;
  logic [767:0] core_round_keys;

  always #5 clk = ~clk;

  des_core_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .msg0(msg0), .msg1(msg1), .keys0(keys0), .keys1(keys1),
    .ack0(ack0), .ack1(ack1), .valid0(valid0), .valid1(valid1),
    .result(result), .err(err), .busy(busy), .core_start(core_start),
    .core_message(core_message), .core_round_keys(core_round_keys),
    .core_done(core_done), .core_result(core_result)
  );

  typedef struct packed {
    logic        idx;
    logic [63:0] res;
    logic        err;
  } resp_t;

  int    checks = 0;
  int    errors = 0;
  resp_t exp_resp_q[$];
  logic  exp_ack_q[$];

  // Core stand-in: knows the reference DES vector, otherwise a keyed mix.
  function automatic logic [63:0] core_model(input logic [63:0] m, input logic [767:0] k);
    if (m == PT && k == KS) return CT;
    return m ^ k[63:0] ^ k[767:704];
  endfunction

  int           stub_lat = 1;
  int           stub_cnt = 0;
  int           start_cnt = 0;
  logic [63:0]  stub_m = '0;
  logic [767:0] stub_k = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_cnt <= 0;
    end else if (core_start) begin
      stub_cnt <= stub_lat;
      stub_m   <= core_message;
      stub_k   <= core_round_keys;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (core_start) start_cnt <= start_cnt + 1;
  end

  assign core_done   = (stub_cnt == 1);
  assign core_result = core_done ? core_model(stub_m, stub_k) : 64'hDEADBEEFDEADBEEF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT acks or delivers a result.
  resp_t mon_r;
  logic  mon_a;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (ack0 || ack1 || core_start) begin
        if (exp_ack_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: ack0=%0b ack1=%0b core_start=%0b expected none", ack0, ack1, core_start);
        end else begin
          mon_a = exp_ack_q.pop_front();
          chk("ack_idx", ack1, mon_a);
          chk("ack_onehot", ack0 ^ ack1, 1'b1);
          chk("start_with_ack", core_start, 1'b1);
        end
      end
      if (valid0 || valid1) begin
        if (exp_resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: valid0=%0b valid1=%0b result=%0h expected none", valid0, valid1, result);
        end else begin
          mon_r = exp_resp_q.pop_front();
          chk("valid_idx", valid1, mon_r.idx);
          chk("valid_onehot", valid0 ^ valid1, 1'b1);
          chk("result", result, mon_r.res);
          chk("err", err, mon_r.err);
        end
      end
    end
  end

  task automatic push_exp(input logic idx, input logic [63:0] res, input logic e);
    resp_t r;
    r.idx = idx; r.res = res; r.err = e;
    exp_ack_q.push_back(idx);
    exp_resp_q.push_back(r);
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!(valid0 || valid1) && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One request from an idle DUT; checks ack and done-to-valid latency.
  task automatic run_single(input logic idx, input logic [63:0] m, input logic [767:0] k,
                            input int lat, input logic [63:0] exp_res, input logic exp_err,
                            input string tag);
    int n, s0, exp_cyc;
    stub_lat = lat;
    push_exp(idx, exp_res, exp_err);
    if (idx) begin msg1 = m; keys1 = k; req1 = 1'b1; end
    else     begin msg0 = m; keys0 = k; req0 = 1'b1; end
    s0 = start_cnt;
    @(negedge clk);
    chk({tag, "_ack_lat"}, idx ? ack1 : ack0, 1'b1);
    req0 = 1'b0; req1 = 1'b0;
    exp_cyc = (lat >= 1 && lat <= TO) ? lat + 1 : TO + 1;
    wait_valid(n);
    chk({tag, "_valid_lat"}, 64'(n), 64'(exp_cyc));
    @(negedge clk);
    chk({tag, "_idle"}, busy, 1'b0);
    chk({tag, "_starts"}, 64'(start_cnt - s0), 64'd1);
  endtask

  initial begin
    int n, s0;
    logic [63:0]  ma, mb;
    logic [767:0] ka, kb;
    ma = 64'hA5A5_0000_1111_2222; ka = {12{64'h0F0F_1234_5678_9ABC}};
    mb = 64'h5A5A_FFFF_EEEE_DDDD; kb = {12{64'hF0F0_8765_4321_0FED}};

    // Asynchronous reset seen before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ack0", ack0, 1'b0);     chk("rst_ack1", ack1, 1'b0);
    chk("rst_valid0", valid0, 1'b0); chk("rst_valid1", valid1, 1'b0);
    chk("rst_err", err, 1'b0);       chk("rst_busy", busy, 1'b0);
    chk("rst_start", core_start, 1'b0); chk("rst_result", result, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reference DES vector through requester 0
    run_single(1'b0, PT, KS, 3, CT, 1'b0, "t1");

    // Simultaneous requests after reset: grants 0,1,0
    do_reset();
    stub_lat = 2;
    push_exp(1'b0, core_model(ma, ka), 1'b0);
    push_exp(1'b1, core_model(mb, kb), 1'b0);
    push_exp(1'b0, core_model(ma, ka), 1'b0);
    msg0 = ma; keys0 = ka; msg1 = mb; keys1 = kb;
    req0 = 1'b1; req1 = 1'b1;
    s0 = start_cnt;
    for (int g = 0; g < 3; g++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(ack0 || ack1) && n < 50);
      chk("t2_grant_order", ack1, g[0]);
      if (g == 2) begin req0 = 1'b0; req1 = 1'b0; end
    end
    wait_valid(n);
    @(negedge clk);
    chk("t2_idle", busy, 1'b0);
    chk("t2_starts", 64'(start_cnt - s0), 64'd3);

    // Timeout and its boundary against core_done
    run_single(1'b1, mb, kb, 0, 64'd0, 1'b1, "t3_to");
    repeat (2) @(negedge clk);
    chk("t3_hold_result", result, 64'd0);
    chk("t3_hold_err", err, 1'b1);
    run_single(1'b1, ma, kb, TO, core_model(ma, kb), 1'b0, "t3_coinc");
    run_single(1'b0, mb, ka, TO + 1, 64'd0, 1'b1, "t3_late");
    run_single(1'b1, ~ma, ka, TO - 1, core_model(~ma, ka), 1'b0, "t3_edge");

    // Reset in the middle of WAIT abandons the operation
    stub_lat = 10;
    exp_ack_q.push_back(1'b0);
    msg0 = ma; keys0 = ka; req0 = 1'b1;
    @(negedge clk);
    chk("t4_ack", ack0, 1'b1);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_busy", busy, 1'b0);     chk("t4_valid0", valid0, 1'b0);
    chk("t4_err", err, 1'b0);       chk("t4_result", result, 64'd0);
    chk("t4_start", core_start, 1'b0);
    s0 = start_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t4_no_start", 64'(start_cnt - s0), 64'd0);
    run_single(1'b0, mb, kb, 4, core_model(mb, kb), 1'b0, "t4_after");

    // Short req1 pulse while busy must be dropped
    stub_lat = 6;
    push_exp(1'b0, core_model(ma, kb), 1'b0);
    msg0 = ma; keys0 = kb; req0 = 1'b1;
    s0 = start_cnt;
    @(negedge clk);
    chk("t5_ack0", ack0, 1'b1);
    req0 = 1'b0;
    @(negedge clk); req1 = 1'b1;
    @(negedge clk); req1 = 1'b0;
    wait_valid(n);
    repeat (4) @(negedge clk);
    chk("t5_idle", busy, 1'b0);
    chk("t5_starts", 64'(start_cnt - s0), 64'd1);

    chk("sb_ack_drained", 64'(exp_ack_q.size()), 64'd0);
    chk("sb_resp_drained", 64'(exp_resp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
